// File: rtl/hangman_core_param.sv
// Blind-hangman game engine: holds a WORD_LEN-letter secret and scores guesses.
// Each guess is scanned one position per cycle and gets a registered result code.
module hangman_core_param #(
  parameter int  WORD_LEN   = 5,
  parameter int  MAX_MISSES = 7,
  localparam int MISS_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  word_load,
  input  logic [WORD_LEN*5-1:0] word_in,
  input  logic                  new_game,
  input  logic                  guess_valid,
  input  logic [4:0]            guess_letter,
  output logic                  guess_ready,
  output logic                  busy,
  output logic                  guess_ack,
  output logic [1:0]            guess_result,
  output logic [WORD_LEN-1:0]   found,
  output logic [MISS_W-1:0]     miss_count,
  output logic                  win,
  output logic                  lose
);

  localparam int                IDX_W       = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(WORD_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_MAX    = MISS_W'(MAX_MISSES);
  localparam logic [4:0]        LETTER_MAX  = 5'd25;
  localparam logic [1:0]        RES_MISS    = 2'b00;
  localparam logic [1:0]        RES_HIT     = 2'b01;
  localparam logic [1:0]        RES_REPEAT  = 2'b10;
  localparam logic [1:0]        RES_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_SCAN, S_UPDATE, S_WIN, S_LOSE
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            word_q [WORD_LEN];
  logic [4:0]            word_d [WORD_LEN];
  logic [WORD_LEN-1:0]   found_q, found_d;
  logic [MISS_W-1:0]     miss_q, miss_d, miss_nx;
  logic [25:0]           mask_q, mask_d;
  logic [4:0]            letter_q, letter_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            pend_q, pend_d;
  logic                  ack_q, ack_d;
  logic [1:0]            result_q, result_d;

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (v >= MISS_MAX) ? v : v + MISS_W'(1);
  endfunction

  // Out-of-alphabet codes in the secret count as already revealed.
  function automatic logic [WORD_LEN-1:0] prerevealed(input logic [WORD_LEN*5-1:0] w);
    logic [WORD_LEN-1:0] r;
    for (int i = 0; i < WORD_LEN; i++) begin
      r[i] = (w[5*i +: 5] > LETTER_MAX);
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    found_d  = found_q;
    miss_d   = miss_q;
    miss_nx  = miss_q;
    mask_d   = mask_q;
    letter_d = letter_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    ack_d    = 1'b0;
    result_d = result_q;

    case (state_q)
      S_READY: begin
        if (guess_valid) begin
          letter_d = guess_letter;
          if (guess_letter > LETTER_MAX) begin
            pend_d  = RES_INVALID;
            state_d = S_UPDATE;
          end else if (mask_q[guess_letter]) begin
            pend_d  = RES_REPEAT;
            state_d = S_UPDATE;
          end else begin
            mask_d[guess_letter] = 1'b1;
            idx_d   = '0;
            pend_d  = RES_MISS;
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (word_q[idx_q] == letter_q) begin
          found_d[idx_q] = 1'b1;
          pend_d         = RES_HIT;
        end
        if (idx_q == LAST_IDX) state_d = S_UPDATE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      S_UPDATE: begin
        ack_d    = 1'b1;
        result_d = pend_q;
        if (pend_q == RES_MISS) miss_nx = sat_inc(miss_q);
        miss_d = miss_nx;
        if (&found_q)                 state_d = S_WIN;
        else if (miss_nx == MISS_MAX) state_d = S_LOSE;
        else                          state_d = S_READY;
      end
      default: ;
    endcase

    // Strobes abort any guess in flight; word_load outranks new_game.
    if (new_game) begin
      found_d = '0;
      miss_d  = '0;
      mask_d  = '0;
      ack_d   = 1'b0;
      state_d = S_IDLE;
    end
    if (word_load) begin
      for (int i = 0; i < WORD_LEN; i++) word_d[i] = word_in[5*i +: 5];
      found_d = prerevealed(word_in);
      miss_d  = '0;
      mask_d  = '0;
      ack_d   = 1'b0;
      state_d = S_READY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < WORD_LEN; i++) word_q[i] <= '0;
      found_q  <= '0;
      miss_q   <= '0;
      mask_q   <= '0;
      letter_q <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      ack_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      found_q  <= found_d;
      miss_q   <= miss_d;
      mask_q   <= mask_d;
      letter_q <= letter_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      result_q <= result_d;
    end
  end

  assign guess_ready  = (state_q == S_READY);
  assign busy         = (state_q == S_SCAN) || (state_q == S_UPDATE);
  assign guess_ack    = ack_q;
  assign guess_result = result_q;
  assign found        = found_q;
  assign miss_count   = miss_q;
  assign win          = (state_q == S_WIN);
  assign lose         = (state_q == S_LOSE);

endmodule

// File: tb/tb_hangman_core_param.sv
// Bench for hangman_core_param: a 5-letter/7-miss instance and an 8-letter/3-miss instance.
module tb_hangman_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, new_game;
  logic [4:0]  letter;
  logic        wl5, gv5, wl8, gv8;
  logic [24:0] wi5;
  logic [39:0] wi8;

  logic       rdy5, busy5, ack5, win5, lose5;
  logic [1:0] res5;
  logic [4:0] found5;
  logic [3:0] miss5;
  logic       rdy8, busy8, ack8, win8, lose8;
  logic [1:0] res8;
  logic [7:0] found8;
  logic [3:0] miss8;

  hangman_core_param #(.WORD_LEN(5), .MAX_MISSES(7)) dut5 (
    .clk(clk), .reset(reset), .word_load(wl5), .word_in(wi5), .new_game(new_game),
    .guess_valid(gv5), .guess_letter(letter), .guess_ready(rdy5), .busy(busy5),
    .guess_ack(ack5), .guess_result(res5), .found(found5), .miss_count(miss5),
    .win(win5), .lose(lose5));

  hangman_core_param #(.WORD_LEN(8), .MAX_MISSES(3)) dut8 (
    .clk(clk), .reset(reset), .word_load(wl8), .word_in(wi8), .new_game(new_game),
    .guess_valid(gv8), .guess_letter(letter), .guess_ready(rdy8), .busy(busy8),
    .guess_ack(ack8), .guess_result(res8), .found(found8), .miss_count(miss8),
    .win(win8), .lose(lose8));

  localparam logic [1:0] MISS = 2'b00, HIT = 2'b01, REP = 2'b10, INV = 2'b11;
  localparam logic [24:0] NOTRE = {5'd4, 5'd17, 5'd19, 5'd14, 5'd13};
  localparam logic [24:0] LEVEL = {5'd11, 5'd4, 5'd21, 5'd4, 5'd11};
  localparam logic [39:0] W8 = {5'd31, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

  typedef struct { logic [1:0] res; int cyc; } exp_t;
  exp_t q5[$];
  exp_t q8[$];

  typedef struct {
    bit          is_load;
    logic [24:0] word;
    logic [4:0]  l;
    logic [1:0]  r;
    int          lat;
    logic [4:0]  f;
    logic [3:0]  m;
    logic        w;
    logic        lo;
  } vec_t;
  vec_t vecs[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation, in result and cycle.
  always @(negedge clk) begin
    if (ack5 === 1'b1) begin
      if (q5.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack5 result=%0d cycle=%0d", res5, cyc);
      end else begin
        exp_t e;
        e = q5.pop_front();
        check("result5", 32'(res5), 32'(e.res));
        check("ack_cycle5", cyc, e.cyc);
      end
    end
    if (ack8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack8 result=%0d cycle=%0d", res8, cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("result8", 32'(res8), 32'(e.res));
        check("ack_cycle8", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit sel, input logic [39:0] w);
    if (sel) begin wl8 = 1'b1; wi8 = w; end
    else     begin wl5 = 1'b1; wi5 = w[24:0]; end
    tick();
    wl5 = 1'b0;
    wl8 = 1'b0;
  endtask

  task automatic do_guess(input bit sel, input logic [4:0] l, input logic [1:0] r, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!(sel ? rdy8 : rdy5) && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL ready_timeout sel=%0d letter=%0d", sel, l);
      return;
    end
    e.res = r;
    e.cyc = cyc + 1 + lat;
    if (sel) q8.push_back(e); else q5.push_back(e);
    letter = l;
    if (sel) gv8 = 1'b1; else gv5 = 1'b1;
    tick();
    gv5 = 1'b0;
    gv8 = 1'b0;
    n = 0;
    while ((sel ? q8.size() : q5.size()) != 0 && n < 40) begin tick(); n++; end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL ack_timeout sel=%0d letter=%0d actual=none expected=%0d", sel, l, r);
      if (sel) q8.delete(); else q5.delete();
    end
  endtask

  function automatic vec_t LV(input logic [24:0] w);
    vec_t v;
    v = '{1'b1, w, 5'd0, 2'd0, 0, 5'd0, 4'd0, 1'b0, 1'b0};
    return v;
  endfunction

  function automatic vec_t GV(input logic [4:0] l, input logic [1:0] r, input int lat,
                              input logic [4:0] f, input logic [3:0] m, input logic w,
                              input logic lo);
    vec_t v;
    v = '{1'b0, 25'd0, l, r, lat, f, m, w, lo};
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; new_game = 1'b0; letter = '0;
    wl5 = 1'b0; gv5 = 1'b0; wl8 = 1'b0; gv8 = 1'b0; wi5 = '0; wi8 = '0;

    // notre: win path
    vecs.push_back(LV(NOTRE));
    vecs.push_back(GV(5'd13, HIT, 6, 5'b00001, 4'd0, 1'b0, 1'b0));
    vecs.push_back(GV(5'd14, HIT, 6, 5'b00011, 4'd0, 1'b0, 1'b0));
    vecs.push_back(GV(5'd19, HIT, 6, 5'b00111, 4'd0, 1'b0, 1'b0));
    vecs.push_back(GV(5'd17, HIT, 6, 5'b01111, 4'd0, 1'b0, 1'b0));
    vecs.push_back(GV(5'd4,  HIT, 6, 5'b11111, 4'd0, 1'b1, 1'b0));
    // repeats and invalid codes
    vecs.push_back(LV(NOTRE));
    vecs.push_back(GV(5'd13, HIT,  6, 5'b00001, 4'd0, 1'b0, 1'b0));
    vecs.push_back(GV(5'd13, REP,  1, 5'b00001, 4'd0, 1'b0, 1'b0));
    vecs.push_back(GV(5'd0,  MISS, 6, 5'b00001, 4'd1, 1'b0, 1'b0));
    vecs.push_back(GV(5'd0,  REP,  1, 5'b00001, 4'd1, 1'b0, 1'b0));
    vecs.push_back(GV(5'd30, INV,  1, 5'b00001, 4'd1, 1'b0, 1'b0));
    vecs.push_back(GV(5'd31, INV,  1, 5'b00001, 4'd1, 1'b0, 1'b0));
    // level: multiple positions per letter
    vecs.push_back(LV(LEVEL));
    vecs.push_back(GV(5'd4,  HIT, 6, 5'b01010, 4'd0, 1'b0, 1'b0));
    vecs.push_back(GV(5'd11, HIT, 6, 5'b11011, 4'd0, 1'b0, 1'b0));
    vecs.push_back(GV(5'd21, HIT, 6, 5'b11111, 4'd0, 1'b1, 1'b0));
    // seven distinct misses: lose
    vecs.push_back(LV(NOTRE));
    vecs.push_back(GV(5'd0, MISS, 6, 5'b0, 4'd1, 1'b0, 1'b0));
    vecs.push_back(GV(5'd1, MISS, 6, 5'b0, 4'd2, 1'b0, 1'b0));
    vecs.push_back(GV(5'd2, MISS, 6, 5'b0, 4'd3, 1'b0, 1'b0));
    vecs.push_back(GV(5'd3, MISS, 6, 5'b0, 4'd4, 1'b0, 1'b0));
    vecs.push_back(GV(5'd5, MISS, 6, 5'b0, 4'd5, 1'b0, 1'b0));
    vecs.push_back(GV(5'd6, MISS, 6, 5'b0, 4'd6, 1'b0, 1'b0));
    vecs.push_back(GV(5'd7, MISS, 6, 5'b0, 4'd7, 1'b0, 1'b1));

    repeat (2) @(posedge clk);
    #1;
    check("reset5", 32'({rdy5, busy5, ack5, res5, found5, miss5, win5, lose5}), 32'd0);
    check("reset8", 32'({rdy8, busy8, ack8, res8, found8, miss8, win8, lose8}), 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      if (v.is_load) do_load(1'b0, {15'd0, v.word});
      else           do_guess(1'b0, v.l, v.r, v.lat);
      check($sformatf("vec%0d_state", i),
            32'({rdy5, found5, miss5, win5, lose5}),
            32'({~(v.w | v.lo), v.f, v.m, v.w, v.lo}));
    end

    // Guesses offered in LOSE are ignored.
    letter = 5'd8; gv5 = 1'b1;
    repeat (3) tick();
    gv5 = 1'b0;
    repeat (10) tick();
    check("lose_hold", 32'({rdy5, busy5, lose5, miss5}), 32'({1'b0, 1'b0, 1'b1, 4'd7}));

    // word_load mid-SCAN aborts the guess and clears the mask.
    do_load(1'b0, {15'd0, NOTRE});
    letter = 5'd13; gv5 = 1'b1;
    tick();
    gv5 = 1'b0;
    tick();
    wl5 = 1'b1; wi5 = LEVEL;
    tick();
    wl5 = 1'b0;
    check("load_abort", 32'({rdy5, busy5, found5, miss5}), 32'({1'b1, 1'b0, 5'd0, 4'd0}));
    repeat (10) tick();
    do_guess(1'b0, 5'd13, MISS, 6);
    check("load_abort_mask", 32'({rdy5, found5, miss5}), 32'({1'b1, 5'd0, 4'd1}));

    // new_game mid-SCAN returns to IDLE with no ack.
    letter = 5'd4; gv5 = 1'b1;
    tick();
    gv5 = 1'b0;
    tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("newgame_abort", 32'({rdy5, busy5, found5, miss5, win5, lose5}), 32'd0);
    letter = 5'd11; gv5 = 1'b1;
    repeat (8) tick();
    gv5 = 1'b0;
    check("newgame_idle", 32'({rdy5, busy5, found5}), 32'd0);

    // Asynchronous reset mid-SCAN.
    do_load(1'b0, {15'd0, NOTRE});
    letter = 5'd13; gv5 = 1'b1;
    tick();
    gv5 = 1'b0;
    tick();
    check("found_in_scan", 32'({busy5, ack5, found5}), 32'({1'b1, 1'b0, 5'b00001}));
    #2 reset = 1'b1;
    #1;
    check("async_reset", 32'({rdy5, busy5, ack5, res5, found5, miss5, win5, lose5}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // 8-letter, 3-miss instance with a pre-revealed position.
    do_load(1'b1, W8);
    check("w8_preset", 32'({rdy8, found8, miss8}), 32'({1'b1, 8'h80, 4'd0}));
    do_guess(1'b1, 5'd0, HIT, 9);
    check("w8_hit", 32'({rdy8, found8, miss8}), 32'({1'b1, 8'h81, 4'd0}));
    for (int k = 0; k < 3; k++) begin
      do_guess(1'b1, 5'(23 + k), MISS, 9);
      check($sformatf("w8_miss%0d", k), 32'({rdy8, found8, miss8, lose8}),
            32'({(k < 2), 8'h81, 4'(k + 1), (k == 2)}));
    end

    repeat (5) tick();
    if (q5.size() != 0 || q8.size() != 0) begin
      checks++; failures++;
      $display("FAIL pending_acks actual=%0d expected=0", q5.size() + q8.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
